tx_code_serializer: RTL
=======================

# tx_code_serializer

Transmit-side symbol stage that sits directly upstream of the seven-segment display decoder. It accepts a 2-bit symbol over a valid/ready handshake and encodes it into the 8-bit pulse code (0→8'b10000000, 1→8'b10100000, 2→8'b10101000, 3→8'b10101010). It presents the latched code to the display stage and serializes it MSB-first onto the transmit line at a programmable bit period, followed by a fixed idle gap.

## Interface
- CLK_DIV, 50000, clock cycles per transmitted bit (≥2)
- GAP_BITS, 2, idle bit periods inserted after each frame (≥1)

- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  asynchronous, active-high reset
- sym_valid  in  1  upstream symbol valid
- sym_data  in  2  symbol value 0..3
- sym_ready  out  1  high when a symbol can be accepted
- code  out  8  most recently accepted pulse code; feeds display stage
- tx_out  out  1  serial transmit line
- busy  out  1  high while in SEND or GAP

## Operation
- One clock; reset is asynchronous and active-high.
- States: IDLE, SEND, GAP.
- IDLE: sym_ready=1, tx_out=0. On sym_valid&&sym_ready, latch encode(sym_data) into code and into the shift register; clear bit counter and divider; go to SEND.
- SEND: tx_out = shift register MSB. Each bit is held CLK_DIV cycles. Then shift left, increment the bit counter. After the last bit, go to GAP.
- GAP: tx_out=0 for GAP_BITS×CLK_DIV cycles, then go to IDLE.
- sym_ready = (state==IDLE), combinational from state. sym_valid outside IDLE is ignored and no symbol is lost; the source holds valid until accepted.
- code changes only on acceptance and holds through SEND, GAP and IDLE.
- busy = (state!=IDLE).
- Reset values: state IDLE, code=8'b10000000 (display shows '0'), tx_out=0, sym_ready=1 once rst is deasserted, busy=0, counters 0.
- Reset asserted mid-frame aborts the frame immediately (asynchronously): tx_out drops to 0 and code returns to 8'b10000000.

## Timing
- Acceptance at edge N. code and tx_out reflect the new frame from edge N (registered outputs, visible cycle N+1).
- Bit k (k=0 is the MSB) occupies cycles [N+1+k·CLK_DIV, N+1+(k+1)·CLK_DIV).
- Frame length: F bits (F=8, or 9 with parity).
- GAP follows immediately for GAP_BITS·CLK_DIV cycles.
- sym_ready reasserts at cycle N+1+(F+GAP_BITS)·CLK_DIV.
- Back-to-back symbols therefore have period (F+GAP_BITS)·CLK_DIV+1 cycles, including the IDLE acceptance cycle.
- Divider counter width: $clog2(CLK_DIV). Bit counter width: 4. Gap counter width: $clog2(GAP_BITS+1).
- Divider wraps at CLK_DIV-1. No overflow is possible within legal parameter values.

## Configuration
- TX_PARITY_EN defined: SEND transmits a 9th bit after the code LSB. That bit is the XOR of the 8 code bits (even parity), giving F=9. Expected parity bits: symbol 0→1, 1→0, 2→1, 3→0.
- TX_PARITY_EN undefined: F=8, no parity logic is compiled, and GAP follows the LSB directly.

## Structure
- Package tx_code_pkg holds:
  - the four code constants (CODE_0..CODE_3);
  - the state enum (IDLE/SEND/GAP);
  - function encode_sym(2-bit)→8-bit.
- The display stage imports the same code constants.
- Sub-module tx_bit_timer, (CLK_DIV):
  - inputs clk, rst, clear, en; output tick, pulsed every CLK_DIV enabled cycles;
  - shared by SEND and GAP for bit and gap timing.

## Test plan
All scenarios use CLK_DIV=4, GAP_BITS=2.
- Reset check: assert rst mid-cycle → code=8'b10000000, tx_out=0, sym_ready=1, busy=0 immediately and after release.
- Encode/serialize: send symbol 2 → code=8'b10101000. tx_out sequence is 1,0,1,0,1,0,0,0, each bit held 4 cycles, then 8 cycles low. sym_ready returns 41 cycles after acceptance (45 with TX_PARITY_EN, with parity bit 1).
- Backpressure: hold sym_valid=1 with symbol 3 while busy after symbol 1 → symbol 3 is accepted exactly on the first IDLE cycle. code goes 8'b10100000 then 8'b10101010.
- Ignored input: toggle sym_data during SEND → code and tx_out are unaffected.
- Reset mid-frame: assert rst at bit 3 of symbol 3 → tx_out=0 and state IDLE at once. The next symbol 0 transmits cleanly: 1 followed by seven 0s.
- All symbols back-to-back 0,1,2,3 → the captured serial bits match the four code constants, and parity (when built with TX_PARITY_EN) reads 1,0,1,0.

Source files
------------

// File: rtl/tx_code_serializer_pkg.sv
// Shared pulse-code constants, serializer state type and symbol encoder.
// Imported by the serializer and by the downstream display decoder; no timing of its own.
package tx_code_pkg;

    localparam logic [7:0] CODE_0 = 8'b1000_0000;
    localparam logic [7:0] CODE_1 = 8'b1010_0000;
    localparam logic [7:0] CODE_2 = 8'b1010_1000;
    localparam logic [7:0] CODE_3 = 8'b1010_1010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } tx_state_t;

    function automatic logic [7:0] encode_sym(input logic [1:0] sym);
        logic [7:0] enc;
        case (sym)
            2'd0:    enc = CODE_0;
            2'd1:    enc = CODE_1;
            2'd2:    enc = CODE_2;
            default: enc = CODE_3;
        endcase
        return enc;
    endfunction

endpackage

// File: rtl/tx_code_serializer_if.sv
// Symbol handshake plus code/serial outputs of the transmit serializer.
// master = symbol source / observer, slave = serializer.
interface tx_code_serializer_if;
    logic       sym_valid;
    logic [1:0] sym_data;
    logic       sym_ready;
    logic [7:0] code;
    logic       tx_out;
    logic       busy;

    modport master (
        output sym_valid, sym_data,
        input  sym_ready, code, tx_out, busy
    );

    modport slave (
        input  sym_valid, sym_data,
        output sym_ready, code, tx_out, busy
    );
endinterface

// File: rtl/tx_code_serializer_bit_timer.sv
// Bit-period divider: tick pulses on every CLK_DIV-th enabled cycle, clear restarts the period.
// Latency: tick is combinational from the count; no backpressure.
module tx_bit_timer #(
    parameter int CLK_DIV = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic tick
);
    localparam int           W    = $clog2(CLK_DIV);
    localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + W'(1);
        end
    end

    assign tick = en && !clear && (cnt == LAST);

endmodule

// File: rtl/tx_code_serializer.sv
// Encodes an accepted 2-bit symbol to its pulse code and shifts it out MSB-first, then idles GAP_BITS periods.
// Outputs registered (acceptance edge + 1); sym_ready only in IDLE. TX_PARITY_EN appends an even-parity bit.
module tx_code_serializer
    import tx_code_pkg::*;
#(
    parameter int CLK_DIV  = 50000,
    parameter int GAP_BITS = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    tx_code_serializer_if.slave  bus
);
`ifdef TX_PARITY_EN
    localparam int FRAME_BITS = 9;
`else
    localparam int FRAME_BITS = 8;
`endif
    localparam int            GW       = $clog2(GAP_BITS + 1);
    localparam logic [3:0]    LAST_BIT = 4'(FRAME_BITS - 1);
    localparam logic [GW-1:0] LAST_GAP = GW'(GAP_BITS - 1);

    tx_state_t             state;
    tx_state_t             state_nxt;
    logic [FRAME_BITS-1:0] shift_q;
    logic [FRAME_BITS-1:0] frame_init;
    logic [7:0]            code_q;
    logic [7:0]            enc;
    logic [3:0]            bit_cnt;
    logic [GW-1:0]         gap_cnt;
    logic                  accept;
    logic                  timer_en;
    logic                  tick;

    assign accept   = bus.sym_valid && (state == IDLE);
    assign timer_en = (state != IDLE);
    assign enc      = encode_sym(bus.sym_data);

`ifdef TX_PARITY_EN
    assign frame_init = {enc, ^enc};
`else
    assign frame_init = enc;
`endif

    tx_bit_timer #(.CLK_DIV(CLK_DIV)) u_bit_timer (
        .clk   (clk),
        .rst   (rst),
        .clear (accept),
        .en    (timer_en),
        .tick  (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = SEND;
            SEND:    if (tick && (bit_cnt == LAST_BIT)) state_nxt = GAP;
            GAP:     if (tick && (gap_cnt == LAST_GAP)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            code_q  <= CODE_0;
            shift_q <= '0;
            bit_cnt <= '0;
            gap_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        code_q  <= enc;
                        shift_q <= frame_init;
                        bit_cnt <= '0;
                        gap_cnt <= '0;
                    end
                end
                SEND: begin
                    if (tick) begin
                        shift_q <= shift_q << 1;
                        bit_cnt <= bit_cnt + 4'd1;
                    end
                end
                GAP: begin
                    if (tick) begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // tx_out is derived only from flops, so reset forces it low without waiting for a clock.
    assign bus.tx_out    = (state == SEND) && shift_q[FRAME_BITS-1];
    assign bus.sym_ready = (state == IDLE);
    assign bus.busy      = (state != IDLE);
    assign bus.code      = code_q;

endmodule
